// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM state type for the OTTER register-file dump engine.
package reg_dump_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned ADDR_W         = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_word_serializer.sv
// Latches one register word and presents it MSB byte first; advances one byte
// per accepted handshake and flags the final byte of the word.
module word_serializer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ack_i,
  output logic [7:0]        byte_o,
  output logic              last_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign byte_o = word_q[DATA_W-1 -: 8];
  assign last_o = (cnt_q == CNT_W'(NBYTES - 1));

  // The final byte is not shifted out, so the word stays put until the next load.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (ack_i && !last_o) begin
      word_d = word_q << 8;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_dump.sv
// Walks every architectural register through one combinational read port and
// streams each word out MSB byte first over a valid/ready byte interface.
module reg_dump #(
  parameter int unsigned NUM_REGS = reg_dump_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = reg_dump_pkg::ADDR_W,
  parameter int unsigned DATA_W   = reg_dump_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RF_ADDR,
  input  logic [DATA_W-1:0] RF_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  import reg_dump_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              load;
  logic              ack;
  logic              last_byte;

  assign TX_VALID = (state_q == S_SEND);
  assign ack      = TX_VALID && TX_READY;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign RF_ADDR  = (state_q == S_IDLE) ? '0 : idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (ack && last_byte) begin
          if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .load_i (load),
    .word_i (RF_DATA),
    .ack_i  (ack),
    .byte_o (TX_DATA),
    .last_o (last_byte)
  );

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: register-file model, byte capture, and
// hand-computed expectations for reset, full dumps, backpressure and restarts.
module tb_reg_dump;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        TX_READY;
  logic        BUSY;
  logic        DONE;
  logic        TX_VALID;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_DATA;
  logic [7:0]  TX_DATA;

  logic [31:0] rf [32];
  logic [7:0]  got [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          max_addr;

  always #5 CLK = ~CLK;

  assign RF_DATA = rf[RF_ADDR];

  always @(posedge CLK)
    if (RST_N && TX_VALID && TX_READY) got.push_back(TX_DATA);

  reg_dump #(
    .NUM_REGS (32),
    .ADDR_W   (5),
    .DATA_W   (32)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RF_ADDR  (RF_ADDR),
    .RF_DATA  (RF_DATA),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic chk_byte(input string tag, input int i, input logic [7:0] exp);
    logic [7:0] b;
    b = (i < got.size()) ? got[i] : 8'hxx;
    chk(tag, {24'h0, b}, {24'h0, exp});
  endtask

  task automatic check_stream(input string tag);
    int         bad;
    logic [31:0] w;
    logic [7:0]  e;
    bad = 0;
    chk({tag, "_count"}, got.size(), 128);
    for (int i = 0; i < 128; i++) begin
      w = rf[i / 4];
      e = 8'((w >> (8 * (3 - (i % 4)))) & 32'hFF);
      if (i >= got.size() || got[i] !== e) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
  endtask

  // mode 0: ready high; 1: random ready; 2: backpressure on 0x22 plus stray
  // START; 3: rewrite x5 one cycle after its LOAD.
  task automatic run_dump(input int mode, output int done_cyc, output int unstable);
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    int         bp_left;
    bit         bp_done;
    got.delete();
    done_cyc = -1;
    unstable = 0;
    bp_left  = 0;
    bp_done  = 0;
    max_addr = 0;
    START    = 1'b1;
    TX_READY = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc      = 0;
    tick();
    START  = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b1;
    prev_d = 8'h00;
    for (int k = 0; k < 2000; k++) begin
      if (prev_v && !prev_r && (!TX_VALID || TX_DATA !== prev_d)) unstable++;
      if (int'(RF_ADDR) > max_addr) max_addr = int'(RF_ADDR);
      if (mode == 0 && cyc == 1) begin
        chk("c1_busy", BUSY, 1);
        chk("c1_valid", TX_VALID, 0);
      end
      if (mode == 0 && cyc == 2) chk("c2_valid", TX_VALID, 1);
      if (mode == 0 && cyc == 160) chk("c160_valid", TX_VALID, 1);
      if (DONE) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        1: TX_READY = 1'($urandom_range(0, 1));
        2: begin
          if (!bp_done && TX_VALID && TX_DATA == 8'h22) begin
            bp_left = 3;
            bp_done = 1;
          end
          if (bp_left > 0) begin
            chk("bp_data", TX_DATA, 8'h22);
            chk("bp_valid", TX_VALID, 1);
            TX_READY = 1'b0;
            bp_left--;
          end else begin
            TX_READY = 1'b1;
          end
          START = (cyc == 40);
        end
        3: if (cyc == 27) rf[5] = 32'hCAFEF00D;
        default: TX_READY = 1'b1;
      endcase
      prev_v = TX_VALID;
      prev_r = TX_READY;
      prev_d = TX_DATA;
      tick();
    end
    START = 1'b0;
    if (mode == 2) chk("bp_seen", bp_done, 1);
  endtask

  initial begin
    int dc, uns;
    for (int i = 0; i < 32; i++) rf[i] = i;
    rf[1]    = 32'h11223344;
    rf[31]   = 32'hDEADBEEF;
    RST_N    = 1'b0;
    START    = 1'b0;
    TX_READY = 1'b1;
    @(negedge CLK);
    tick();
    tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_valid", TX_VALID, 0);
    chk("rst_data", TX_DATA, 8'h00);
    chk("rst_addr", RF_ADDR, 0);
    RST_N = 1'b1;
    tick();

    run_dump(0, dc, uns);
    chk("full_done_cycle", dc, 161);
    chk_byte("b0", 0, 8'h00);
    chk_byte("b3", 3, 8'h00);
    chk_byte("b4", 4, 8'h11);
    chk_byte("b5", 5, 8'h22);
    chk_byte("b6", 6, 8'h33);
    chk_byte("b7", 7, 8'h44);
    chk_byte("b124", 124, 8'hDE);
    chk_byte("b125", 125, 8'hAD);
    chk_byte("b126", 126, 8'hBE);
    chk_byte("b127", 127, 8'hEF);
    check_stream("full");
    tick();
    chk("c162_busy", BUSY, 0);
    chk("c162_done", DONE, 0);
    chk("c162_valid", TX_VALID, 0);
    chk("c162_addr", RF_ADDR, 0);

    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("mid_valid_pre", TX_VALID | BUSY, 1);
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    chk("mrst_busy", BUSY, 0);
    chk("mrst_valid", TX_VALID, 0);
    chk("mrst_addr", RF_ADDR, 0);
    chk("mrst_done", DONE, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("mrst_no_resume", BUSY | TX_VALID | DONE, 0);
    run_dump(0, dc, uns);
    chk("redump_done_cycle", dc, 161);
    chk_byte("redump_b0", 0, 8'h00);
    chk_byte("redump_b4", 4, 8'h11);
    check_stream("redump");

    run_dump(2, dc, uns);
    chk("bp_done_seen", dc > 0, 1);
    chk("bp_stable", uns, 0);
    check_stream("bp");
    START = 1'b1;
    tick();
    chk("hold_idle_busy", BUSY, 0);
    chk("hold_idle_done", DONE, 0);
    tick();
    chk("hold_load_busy", BUSY, 1);
    chk("hold_load_valid", TX_VALID, 0);
    tick();
    chk("hold_send_valid", TX_VALID, 1);
    chk("hold_send_data", TX_DATA, 8'h00);
    START = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

    run_dump(3, dc, uns);
    chk("wr_done_cycle", dc, 161);
    chk_byte("wr_b20", 20, 8'h00);
    chk_byte("wr_b21", 21, 8'h00);
    chk_byte("wr_b22", 22, 8'h00);
    chk_byte("wr_b23", 23, 8'h05);
    rf[5] = 32'h5;
    check_stream("wr");
    tick();

    for (int i = 2; i < 31; i++) rf[i] = $urandom;
    run_dump(1, dc, uns);
    chk("rnd_done_seen", dc > 0, 1);
    chk("rnd_stable", uns, 0);
    chk("rnd_addr_le31", max_addr <= 31, 1);
    check_stream("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the OTTER register file: on a start request it walks all 32 architectural registers through one asynchronous read port of the register file, latches each word, and streams it out as bytes over a valid/ready byte interface (UART TX or debug FIFO). It is the reader-side counterpart of the register file and sits beside the CPU core in the debug path.

## Interface
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width; must be a multiple of 8
- CLK  input  1  rising-edge clock, shared with the register file
- RST_N  input  1  reset; synchronous, active-low
- START  input  1  dump request; sampled only in IDLE
- BUSY  output  1  high from the cycle after START is accepted until DONE cycle inclusive
- DONE  output  1  one-cycle pulse after the last byte handshakes
- RF_ADDR  output  ADDR_W  register file read address (drives a read port)
- RF_DATA  input  DATA_W  combinational read data for RF_ADDR
- TX_DATA  output  8  byte being offered
- TX_VALID  output  1  byte valid
- TX_READY  input  1  sink accepts byte; transfer when TX_VALID && TX_READY at a rising edge

## Operation
- States: IDLE, LOAD, SEND, FIN.
- IDLE: BUSY=0, TX_VALID=0, RF_ADDR=0. START=1 -> LOAD, reg index=0.
- LOAD (1 cycle): RF_ADDR=index; word register <= RF_DATA; byte count=0 -> SEND.
- SEND: TX_VALID=1, TX_DATA=word[DATA_W-1 -: 8] (MSB byte first). On handshake: if byte count=DATA_W/8-1 then (index=NUM_REGS-1 -> FIN, else index+1 -> LOAD); otherwise shift word left 8, byte count+1.
- FIN (1 cycle): DONE=1, BUSY=1 -> IDLE.
- Word is latched in LOAD; register-file writes after LOAD do not alter bytes already latched.
- x0 reads as 0 from the register file and is sent as four 0x00 bytes; no special casing.
- START outside IDLE is ignored. START held high restarts a dump immediately after FIN (IDLE for one cycle).
- Index wraps nowhere: counter saturates at NUM_REGS-1 then FIN; no address beyond NUM_REGS-1 is ever driven.

## Timing
- Reset values (RST_N low at a rising edge): state IDLE, BUSY=0, DONE=0, TX_VALID=0, TX_DATA=0x00, RF_ADDR=0, index=0, byte count=0.
- Reset mid-dump aborts at that edge: TX_VALID=0 the following cycle, no DONE pulse, partial stream is not resumed.
- START sampled at edge 0 -> LOAD in cycle 1, first TX_VALID in cycle 2.
- Per register: 1 LOAD cycle + 4 handshakes. With TX_READY tied high: last SEND cycle 160, DONE in cycle 161, IDLE in cycle 162.
- While TX_VALID=1 and TX_READY=0, TX_DATA and TX_VALID hold stable; TX_VALID never drops without a handshake (except reset).
- TX_VALID does not depend combinationally on TX_READY.
- RF_DATA is used only in LOAD; register-file read is combinational, so no wait state.

## Structure
- Package reg_dump_pkg: state enum (IDLE, LOAD, SEND, FIN), NUM_REGS, BYTES_PER_WORD = DATA_W/8 constants.
- One sub-module: word_serializer (load word, emit bytes MSB-first under valid/ready, flag last byte); reg_dump owns the FSM and register index.

## Test plan
- Reset: RST_N low 2 cycles during a dump -> next cycle BUSY=0, TX_VALID=0, RF_ADDR=0, DONE=0; new START dumps from x0.
- Full dump, TX_READY=1, RF x1=0x11223344, x31=0xDEADBEEF, others i -> 128 bytes; bytes 0-3 = 00 00 00 00, bytes 4-7 = 11 22 33 44, bytes 124-127 = DE AD BE EF; DONE high exactly in cycle 161.
- Backpressure: TX_READY low 3 cycles while offering byte 0x22 -> TX_DATA stays 0x22, TX_VALID stays 1; byte count totals 128, no duplicates/losses.
- START pulsed during SEND -> ignored, exactly one DONE; START held high -> second dump begins with LOAD two cycles after DONE.
- Write x5=0xCAFEF00D to register file one cycle after LOAD of x5 (old 0x00000005) -> stream carries 00 00 00 05.
- Random TX_READY (50%) full dump -> byte stream matches register-file snapshot at each LOAD; RF_ADDR never exceeds 31.
